// File: rtl/matrix_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width and
// the row-count values that decide which upper rows carry real data.
package matrix_gen_3x3_pkg;

  localparam int DW_DEF = 8;

  typedef logic [1:0] row_cnt_t;

  localparam row_cnt_t ROW_FIRST  = 2'd0;  // no previous line: rows r-1, r-2 zero
  localparam row_cnt_t ROW_SECOND = 2'd1;  // one previous line: row r-2 zero
  localparam row_cnt_t ROW_FULL   = 2'd2;  // both line buffers hold valid data

endpackage

// File: rtl/line_buf_ram.sv
// Single-address line buffer, read-before-write.
// rdata is the registered pre-write word; old_data is the same word
// combinationally, so a following buffer can be written in the same cycle.
module line_buf_ram
  import matrix_gen_3x3_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] old_data
);

  logic [DW-1:0] mem [DEPTH];

  assign old_data = mem[addr];

  // Registered read of the old word, then optional overwrite.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/matrix_gen_3x3.sv
// 3x3 pixel window generator for the median filter path.
// Two cascaded line buffers supply rows r-1 and r-2; each row feeds three
// column taps. Sync signals are delayed two cycles to match the window.
module matrix_gen_3x3
  import matrix_gen_3x3_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_Y,
  output logic          matrix_frame_vsync,
  output logic          matrix_frame_href,
  output logic          matrix_frame_clken,
  output logic [DW-1:0] matrix_p11,
  output logic [DW-1:0] matrix_p12,
  output logic [DW-1:0] matrix_p13,
  output logic [DW-1:0] matrix_p21,
  output logic [DW-1:0] matrix_p22,
  output logic [DW-1:0] matrix_p23,
  output logic [DW-1:0] matrix_p31,
  output logic [DW-1:0] matrix_p32,
  output logic [DW-1:0] matrix_p33
);

  localparam int            CW       = $clog2(IMG_HDISP);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP - 1);

  logic          acc;
  logic          vsync_d1, href_d1, acc_d1;
  logic          vsync_rise, href_fall;
  logic [CW-1:0] col_cnt;
  row_cnt_t      row_cnt, row_cnt_d1;
  logic [DW-1:0] pix_d1;
  logic [DW-1:0] lb1_rd, lb2_rd, lb1_old, lb2_old_unused;
  logic [DW-1:0] row1_d, row2_d, row3_d;

  assign acc        = per_frame_clken & per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_d1;
  assign href_fall  = href_d1 & ~per_frame_href;

  // Two-deep delay of vsync, href and the accept strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1           <= 1'b0;
      href_d1            <= 1'b0;
      acc_d1             <= 1'b0;
      matrix_frame_vsync <= 1'b0;
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
    end else begin
      vsync_d1           <= per_frame_vsync;
      href_d1            <= per_frame_href;
      acc_d1             <= acc;
      matrix_frame_vsync <= vsync_d1;
      matrix_frame_href  <= href_d1;
      matrix_frame_clken <= acc_d1;
    end
  end

  // Column counter: held at 0 outside a line, wraps so overrun pixels
  // overwrite from column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (!per_frame_href) begin
      col_cnt <= '0;
    end else if (acc) begin
      col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
    end
  end

  // Row counter: vsync rise wins over an href fall in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= ROW_FIRST;
    end else if (vsync_rise) begin
      row_cnt <= ROW_FIRST;
    end else if (href_fall && row_cnt != ROW_FULL) begin
      row_cnt <= row_cnt + 2'd1;
    end
  end

  // Stage 1 capture. row_cnt travels with the pixel so the last pixel of
  // a line is gated by the count it was accepted under.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_d1     <= '0;
      row_cnt_d1 <= ROW_FIRST;
    end else begin
      pix_d1     <= per_img_Y;
      row_cnt_d1 <= row_cnt;
    end
  end

  line_buf_ram #(.DW(DW), .DEPTH(IMG_HDISP), .AW(CW)) u_lb1 (
    .clk      (clk),
    .we       (acc),
    .addr     (col_cnt),
    .wdata    (per_img_Y),
    .rdata    (lb1_rd),
    .old_data (lb1_old)
  );

  line_buf_ram #(.DW(DW), .DEPTH(IMG_HDISP), .AW(CW)) u_lb2 (
    .clk      (clk),
    .we       (acc),
    .addr     (col_cnt),
    .wdata    (lb1_old),
    .rdata    (lb2_rd),
    .old_data (lb2_old_unused)
  );

  // Upper rows forced to zero until enough lines of this frame exist.
  always_comb begin
    row3_d = pix_d1;
    row2_d = lb1_rd;
    row1_d = lb2_rd;
    if (row_cnt_d1 == ROW_FIRST) begin
      row2_d = '0;
      row1_d = '0;
    end else if (row_cnt_d1 == ROW_SECOND) begin
      row1_d = '0;
    end
  end

  // Stage 2: column taps, cleared between lines for left-border zero fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !href_d1) begin
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else if (acc_d1) begin
      matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= row1_d;
      matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= row2_d;
      matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= row3_d;
    end
  end

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Bench for matrix_gen_3x3 with an 8-pixel line. A behavioural model
// pushes the expected window for every accepted pixel onto a scoreboard;
// a negedge monitor pops on each window strobe. Observed windows are also
// logged by (phase, line*16+col) and compared against a constant table.
module tb_matrix_gen_3x3;

  localparam int H  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_frame_vsync, per_frame_href, per_frame_clken;
  logic [DW-1:0] per_img_Y;
  logic          matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;

  always #5 clk = ~clk;

  matrix_gen_3x3 #(.IMG_HDISP(H), .DW(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_Y          (per_img_Y),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_p11         (matrix_p11),
    .matrix_p12         (matrix_p12),
    .matrix_p13         (matrix_p13),
    .matrix_p21         (matrix_p21),
    .matrix_p22         (matrix_p22),
    .matrix_p23         (matrix_p23),
    .matrix_p31         (matrix_p31),
    .matrix_p32         (matrix_p32),
    .matrix_p33         (matrix_p33)
  );

  logic [71:0] dut_win;
  assign dut_win = {matrix_p11, matrix_p12, matrix_p13,
                    matrix_p21, matrix_p22, matrix_p23,
                    matrix_p31, matrix_p32, matrix_p33};

  typedef struct {
    int          due;
    int          phase;
    int          tag;
    logic [71:0] win;
  } sb_t;

  typedef struct {
    int          phase;
    int          tag;
    logic [71:0] win;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[12];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int phase = 0;
  int pulses [5];
  logic [71:0] obs   [5][256];
  bit          obs_v [5][256];

  // behavioural model state
  logic [7:0] lb1m [H];
  logic [7:0] lb2m [H];
  logic [7:0] t1 [3];
  logic [7:0] t2 [3];
  logic [7:0] t3 [3];
  int   m_col, m_row;
  logic m_pvs, m_phr;

  always @(posedge clk) cyc++;

  task automatic model_reset();
    m_col = 0; m_row = 0; m_pvs = 1'b0; m_phr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      t1[k] = 8'h00; t2[k] = 8'h00; t3[k] = 8'h00;
    end
  endtask

  // Apply one cycle of input and update the model; call right after a posedge.
  task automatic drive(input logic vs, input logic hr, input logic ce,
                       input logic [7:0] y, input int tag);
    sb_t e;
    logic [7:0] r1, r2;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_Y       = y;
    if (!hr) begin
      for (int k = 0; k < 3; k++) begin
        t1[k] = 8'h00; t2[k] = 8'h00; t3[k] = 8'h00;
      end
    end else if (ce) begin
      r2 = (m_row >= 1) ? lb1m[m_col] : 8'h00;
      r1 = (m_row >= 2) ? lb2m[m_col] : 8'h00;
      lb2m[m_col] = lb1m[m_col];
      lb1m[m_col] = y;
      t1[0] = t1[1]; t1[1] = t1[2]; t1[2] = r1;
      t2[0] = t2[1]; t2[1] = t2[2]; t2[2] = r2;
      t3[0] = t3[1]; t3[1] = t3[2]; t3[2] = y;
      e.due   = cyc + 2;
      e.phase = phase;
      e.tag   = tag;
      e.win   = {t1[0], t1[1], t1[2], t2[0], t2[1], t2[2], t3[0], t3[1], t3[2]};
      sb.push_back(e);
    end
    if (!hr) m_col = 0;
    else if (ce) m_col = (m_col == H - 1) ? 0 : m_col + 1;
    if (vs && !m_pvs) m_row = 0;
    else if (m_phr && !hr && m_row < 2) m_row = m_row + 1;
    m_pvs = vs;
    m_phr = hr;
  endtask

  task automatic line(input logic vs, input logic vs_blank, input int lidx,
                      input int npix, input bit gaps, input logic [7:0] base);
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      drive(vs, 1'b1, 1'b1, base + 8'(i), lidx * 16 + i);
      if (gaps) begin
        @(posedge clk); #1;
        drive(vs, 1'b1, 1'b0, 8'hEE, 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(vs_blank, 1'b0, 1'b0, 8'h00, 0);
    end
  endtask

  task automatic idle(input logic vs, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(vs, 1'b0, 1'b0, 8'h00, 0);
    end
  endtask

  task automatic drain_check(input string name);
    idle(1'b0, 4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d windows never produced, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({dut_win, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h vs=%b hr=%b ce=%b, required all 0", name,
               dut_win, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken);
    end
  endtask

  // Scoreboard monitor: every window strobe must match the oldest expectation
  // both in content and in arrival cycle.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n === 1'b1 && matrix_frame_clken === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: got %h at cyc %0d, required no strobe", dut_win, cyc);
      end else begin
        e = sb.pop_front();
        if (dut_win !== e.win || cyc != e.due) begin
          errors++;
          $display("FAIL window ph%0d tag %02h: got %h at cyc %0d, required %h at cyc %0d",
                   e.phase, e.tag, dut_win, cyc, e.win, e.due);
        end
        obs[e.phase][e.tag]   = dut_win;
        obs_v[e.phase][e.tag] = 1'b1;
        pulses[e.phase]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Window table: {phase, line*16+col, p11..p33}
    tbl[0]  = '{1, 'h22, 72'h000102_101112_202122};
    tbl[1]  = '{1, 'h05, 72'h000000_000000_030405};
    tbl[2]  = '{1, 'h10, 72'h000000_000000_000010};
    tbl[3]  = '{1, 'h37, 72'h151617_252627_353637};
    tbl[4]  = '{1, 'h13, 72'h000000_010203_111213};
    tbl[5]  = '{1, 'h20, 72'h000000_000010_000020};
    tbl[6]  = '{1, 'h31, 72'h001011_002021_003031};
    tbl[7]  = '{3, 'h32, 72'h101112_202122_303132};
    tbl[8]  = '{3, 'h42, 72'h000000_000000_404142};
    tbl[9]  = '{4, 'h09, 72'h000000_000000_575859};
    tbl[10] = '{4, 'h11, 72'h000000_005859_006061};
    tbl[11] = '{4, 'h12, 72'h000000_585952_606162};

    for (int k = 0; k < H; k++) begin
      lb1m[k] = 8'h00; lb2m[k] = 8'h00;
    end
    for (int p = 0; p < 5; p++) pulses[p] = 0;
    model_reset();
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    per_frame_clken = 1'b0; per_img_Y = 8'h00;
    repeat (2) @(posedge clk);

    // Reset held with an active stream: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      per_frame_vsync = 1'b1; per_frame_href = 1'b1;
      per_frame_clken = 1'b1; per_img_Y = 8'(i + 1);
      @(negedge clk);
      chk_zero("reset_hold");
    end

    // Release with the stream running: first window two cycles after first accept.
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase = 0;
    model_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h77, 0);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b1, 8'(8'h77 + i), i);
    end

    // Asynchronous reset mid-line clears outputs without waiting for a clock.
    @(posedge clk); #3;
    rst_n = 1'b0;
    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0);

    // Ramp frame, continuous clken.
    phase = 1;
    idle(1'b0, 3);
    for (int l = 0; l < 4; l++) line(1'b1, 1'b1, l, 8, 1'b0, 8'(16 * l));
    drain_check("drain_ramp");

    // Same ramp with clken toggling 1,0.
    phase = 2;
    idle(1'b0, 3);
    for (int l = 0; l < 4; l++) line(1'b1, 1'b1, l, 8, 1'b1, 8'(16 * l));
    drain_check("drain_gaps");

    // Frame restart; vsync rise coincides with an href fall.
    phase = 3;
    idle(1'b0, 3);
    for (int l = 0; l < 3; l++) line(1'b1, 1'b1, l, 8, 1'b0, 8'(16 * l));
    line(1'b0, 1'b1, 3, 8, 1'b0, 8'h30);
    line(1'b1, 1'b1, 4, 8, 1'b0, 8'h40);
    drain_check("drain_restart");

    // Line overrun: 10 pixels on an 8-pixel line.
    phase = 4;
    idle(1'b0, 3);
    line(1'b1, 1'b1, 0, 10, 1'b0, 8'h50);
    line(1'b1, 1'b1, 1, 8, 1'b0, 8'h60);
    drain_check("drain_overrun");

    // Constant-table comparison; ramp entries apply to the gapped run too.
    for (int i = 0; i < 12; i++) begin
      for (int ph = tbl[i].phase; ph <= ((tbl[i].phase == 1) ? 2 : tbl[i].phase); ph++) begin
        checks++;
        if (!obs_v[ph][tbl[i].tag]) begin
          errors++;
          $display("FAIL table ph%0d tag %02h: no window seen, required %h",
                   ph, tbl[i].tag, tbl[i].win);
        end else if (obs[ph][tbl[i].tag] !== tbl[i].win) begin
          errors++;
          $display("FAIL table ph%0d tag %02h: got %h, required %h",
                   ph, tbl[i].tag, obs[ph][tbl[i].tag], tbl[i].win);
        end
      end
    end

    for (int ph = 1; ph <= 2; ph++) begin
      checks++;
      if (pulses[ph] != 32) begin
        errors++;
        $display("FAIL clken_pulses ph%0d: got %0d, required 32", ph, pulses[ph]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
